link_tx: RTL and testbench

LINK_TX -- requirements
Module: link_tx

---
 rtl/link_tx_pkg.sv | 31 +++
 rtl/link_tx_credit_cnt.sv | 34 +++
 rtl/link_tx.sv | 88 ++++++++
 tb/tb_link_tx.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/link_tx_pkg.sv
// Shared definitions for the link transmitter: flit type encodings,
// type-field placement and credit limit derivation.
package link_tx_pkg;

    // Flit type lives in the top two bits of every flit.
    localparam int FLIT_TYPE_W = 2;

    typedef enum logic [FLIT_TYPE_W-1:0] {
        FT_BODY   = 2'b00,
        FT_HEAD   = 2'b01,
        FT_TAIL   = 2'b10,
        FT_SINGLE = 2'b11
    } flit_type_e;

    // MSB of the type field for a flit of width dw.
    function automatic int type_msb(input int dw);
        return dw - 1;
    endfunction

    // LSB of the type field for a flit of width dw.
    function automatic int type_lsb(input int dw);
        return dw - FLIT_TYPE_W;
    endfunction

    // One slot of the downstream buffer is never advertised, so the
    // credit count fits exactly in log2_depth bits.
    function automatic int max_credit(input int log2_depth);
        return (1 << log2_depth) - 1;
    endfunction

endpackage

// File: rtl/link_tx_credit_cnt.sv
// Credit counter for the downstream buffer: decrements on each read,
// increments on each returned credit, saturates at the maximum and
// flags an overflow attempt with a sticky error.
module credit_cnt
    import link_tx_pkg::*;
#(
    parameter int LOG2_DEPTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc,
    input  logic                  dec,
    output logic [LOG2_DEPTH-1:0] credits,
    output logic                  err
);

    localparam logic [LOG2_DEPTH-1:0] MAX_CREDIT = LOG2_DEPTH'(max_credit(LOG2_DEPTH));

    // Simultaneous inc and dec cancel; an inc at the ceiling is dropped and latched as an error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credits <= MAX_CREDIT;
            err     <= 1'b0;
        end else if (inc && !dec) begin
            if (credits == MAX_CREDIT)
                err <= 1'b1;
            else
                credits <= credits + LOG2_DEPTH'(1);
        end else if (dec && !inc) begin
            credits <= credits - LOG2_DEPTH'(1);
        end
    end

endmodule

// File: rtl/link_tx.sv
// Credit-based link transmitter: pops flits from a local registered-read
// FIFO and forwards them downstream one cycle later, tracking packet
// framing, flit/packet counts and protocol errors.
module link_tx
    import link_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 37,
    parameter int LOG2_DEPTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic                  tx_en,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  credit_in,
    output logic [LOG2_DEPTH-1:0] credits,
    output logic [15:0]           flit_cnt,
    output logic [15:0]           pkt_cnt,
    output logic                  credit_err,
    output logic                  proto_err
);

    localparam int TYPE_LSB = type_lsb(DATA_WIDTH);

    logic       rd_pend;
    logic       pkt_open;
    flit_type_e ftype;

    assign ftype = flit_type_e'(fifo_dout[TYPE_LSB +: FLIT_TYPE_W]);

    // With the link disabled, an open packet drains only when no read is in
    // flight, so the tail is seen (and pkt_open cleared) before the next read.
    assign fifo_rd_en = reset && !fifo_empty && (credits != '0) &&
                        (tx_en || (pkt_open && !rd_pend));

    assign tx_data  = fifo_dout;
    assign tx_valid = rd_pend;

    credit_cnt #(
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_credit_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc     (credit_in),
        .dec     (fifo_rd_en),
        .credits (credits),
        .err     (credit_err)
    );

    // Read pipeline, packet framing tracker, counters and sticky protocol error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_pend   <= 1'b0;
            pkt_open  <= 1'b0;
            flit_cnt  <= '0;
            pkt_cnt   <= '0;
            proto_err <= 1'b0;
        end else begin
            rd_pend <= fifo_rd_en;
            if (rd_pend) begin
                flit_cnt <= flit_cnt + 16'd1;
                case (ftype)
                    FT_HEAD: begin
                        if (pkt_open) proto_err <= 1'b1;
                        pkt_open <= 1'b1;
                    end
                    FT_BODY: begin
                        if (!pkt_open) proto_err <= 1'b1;
                    end
                    FT_TAIL: begin
                        if (!pkt_open) proto_err <= 1'b1;
                        pkt_open <= 1'b0;
                        pkt_cnt  <= pkt_cnt + 16'd1;
                    end
                    FT_SINGLE: begin
                        if (pkt_open) proto_err <= 1'b1;
                        pkt_cnt <= pkt_cnt + 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_link_tx.sv
// Directed bench for link_tx: a local FIFO model feeds the DUT, expected
// flits are queued at push time and a negedge monitor pops and compares.
module tb_link_tx;
    import link_tx_pkg::*;

    localparam int DW = 37;
    localparam int LG = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] fifo_dout = '0;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic          tx_en = 1'b0;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          credit_in = 1'b0;
    logic [LG-1:0] credits;
    logic [15:0]   flit_cnt;
    logic [15:0]   pkt_cnt;
    logic          credit_err;
    logic          proto_err;

    int tests = 0;
    int fails = 0;
    int sent  = 0;
    int npush = 0;
    int npop  = 0;
    int sent0;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] e_flit;

    bit t1_rd [5] = '{1, 1, 1, 0, 0};
    bit t1_tv [5] = '{0, 1, 1, 1, 0};
    bit t5_rd [8] = '{1, 0, 1, 0, 1, 0, 0, 0};
    bit t5_tv [8] = '{0, 1, 0, 1, 0, 1, 0, 0};

    link_tx #(.DATA_WIDTH(DW), .LOG2_DEPTH(LG)) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .tx_en      (tx_en),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .credit_in  (credit_in),
        .credits    (credits),
        .flit_cnt   (flit_cnt),
        .pkt_cnt    (pkt_cnt),
        .credit_err (credit_err),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (npush == npop);

    // Local FIFO model with registered read data.
    always @(posedge clk) begin
        if (fifo_rd_en && fq.size() > 0) begin
            fifo_dout <= fq.pop_front();
            npop      <= npop + 1;
        end
    end

    // Monitor: every presented flit must match the head of the expected queue.
    always @(negedge clk) begin
        if (fifo_empty) begin
            tests++;
            if (fifo_rd_en) begin
                fails++;
                $display("FAIL rd_on_empty: fifo_rd_en=1 required 0");
            end
        end
        if (tx_valid) begin
            tests++;
            if (!reset) begin
                fails++;
                $display("FAIL tx_in_reset: tx_valid=1 required 0");
            end else if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_flit: got %h with nothing expected", tx_data);
            end else begin
                e_flit = exp_q.pop_front();
                sent++;
                if (tx_data !== e_flit) begin
                    fails++;
                    $display("FAIL tx_data: got %h required %h", tx_data, e_flit);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input flit_type_e t, input int p);
        return {t, (DW-2)'(p)};
    endfunction

    task automatic push(input logic [DW-1:0] f);
        fq.push_back(f);
        exp_q.push_back(f);
        npush++;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        credit_in = 1'b0;
        fq.delete();
        exp_q.delete();
        npush = npop;
        @(negedge clk);
        check("rst_credits",    32'(credits),    32'd31);
        check("rst_tx_valid",   32'(tx_valid),   32'd0);
        check("rst_flit_cnt",   32'(flit_cnt),   32'd0);
        check("rst_pkt_cnt",    32'(pkt_cnt),    32'd0);
        check("rst_credit_err", 32'(credit_err), 32'd0);
        check("rst_proto_err",  32'(proto_err),  32'd0);
        // A non-empty FIFO must not be read while reset is held.
        fq.push_back(mk(FT_SINGLE, 99));
        npush++;
        #1;
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        fq.delete();
        npush = npop;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Head/body/tail with the link enabled: back-to-back, one-cycle latency.
        do_reset();
        tx_en = 1'b1;
        push(mk(FT_HEAD, 1));
        push(mk(FT_BODY, 2));
        push(mk(FT_TAIL, 3));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("t1_rd_en_%0d", i), 32'(fifo_rd_en), 32'(t1_rd[i]));
            check($sformatf("t1_tx_valid_%0d", i), 32'(tx_valid), 32'(t1_tv[i]));
        end
        step(1);
        check("t1_credits",   32'(credits),   32'd28);
        check("t1_pkt_cnt",   32'(pkt_cnt),   32'd1);
        check("t1_flit_cnt",  32'(flit_cnt),  32'd3);
        check("t1_proto_err", 32'(proto_err), 32'd0);

        // Credit exhaustion: 32 queued, 31 go out, one returned credit releases one more.
        do_reset();
        sent0 = sent;
        for (int i = 0; i < 32; i++) push(mk(FT_SINGLE, 100 + i));
        step(40);
        check("t2_sent31",     32'(sent - sent0), 32'd31);
        check("t2_credits0",   32'(credits),      32'd0);
        check("t2_rd_en_stop", 32'(fifo_rd_en),   32'd0);
        check("t2_still_q",    32'(fifo_empty),   32'd0);
        credit_in = 1'b1;
        step(1);
        credit_in = 1'b0;
        step(5);
        check("t2_sent32",    32'(sent - sent0), 32'd32);
        check("t2_credits_e", 32'(credits),      32'd0);
        check("t2_flit_cnt",  32'(flit_cnt),     32'd32);
        check("t2_pkt_cnt",   32'(pkt_cnt),      32'd32);

        // Simultaneous credit return and read at credits=5.
        credit_in = 1'b1;
        step(5);
        credit_in = 1'b0;
        check("t3_credits5", 32'(credits), 32'd5);
        push(mk(FT_SINGLE, 200));
        credit_in = 1'b1;
        step(1);
        credit_in = 1'b0;
        check("t3_same_cycle", 32'(credits), 32'd5);
        step(3);
        check("t3_credits_after", 32'(credits),  32'd5);
        check("t3_flit_cnt",      32'(flit_cnt), 32'd33);

        // Credit overflow sets a sticky error that survives later traffic.
        do_reset();
        credit_in = 1'b1;
        step(1);
        credit_in = 1'b0;
        check("t4_credits_sat", 32'(credits),    32'd31);
        check("t4_credit_err",  32'(credit_err), 32'd1);
        push(mk(FT_SINGLE, 300));
        push(mk(FT_SINGLE, 301));
        step(4);
        check("t4_credits29", 32'(credits), 32'd29);
        credit_in = 1'b1;
        step(2);
        credit_in = 1'b0;
        check("t4_credits31",  32'(credits),    32'd31);
        check("t4_err_sticky", 32'(credit_err), 32'd1);

        // Link disabled mid-packet: drain at half rate up to the tail, then stop.
        do_reset();
        tx_en = 1'b1;
        push(mk(FT_HEAD, 400));
        step(3);
        tx_en = 1'b0;
        push(mk(FT_BODY, 401));
        push(mk(FT_BODY, 402));
        push(mk(FT_TAIL, 403));
        push(mk(FT_SINGLE, 404));
        push(mk(FT_SINGLE, 405));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("t5_rd_en_%0d", i), 32'(fifo_rd_en), 32'(t5_rd[i]));
            check($sformatf("t5_tx_valid_%0d", i), 32'(tx_valid), 32'(t5_tv[i]));
        end
        step(10);
        check("t5_rd_en_idle", 32'(fifo_rd_en), 32'd0);
        check("t5_flit_cnt",   32'(flit_cnt),   32'd4);
        check("t5_pkt_cnt",    32'(pkt_cnt),    32'd1);
        check("t5_queued",     32'(fifo_empty), 32'd0);
        check("t5_proto_err",  32'(proto_err),  32'd0);
        tx_en = 1'b1;
        step(5);
        check("t5_flit_cnt_re", 32'(flit_cnt), 32'd6);
        check("t5_pkt_cnt_re",  32'(pkt_cnt),  32'd3);

        // Body outside a packet raises proto_err; reset with a read pending.
        do_reset();
        tx_en = 1'b1;
        push(mk(FT_BODY, 500));
        step(4);
        check("t6_proto_err", 32'(proto_err), 32'd1);
        check("t6_flit_cnt",  32'(flit_cnt),  32'd1);
        check("t6_pkt_cnt",   32'(pkt_cnt),   32'd0);
        push(mk(FT_SINGLE, 501));
        step(1);
        check("t6_pending", 32'(tx_valid), 32'd1);
        do_reset();
        step(3);
        check("t6_post_flit_cnt", 32'(flit_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
